// File: rtl/counter_pattern_decoder_if.sv
// Pattern-sample bundle between the LED counters and the decoder.
// master drives samples; slave returns decoded status.
interface counter_pattern_decoder_if #(
    parameter int ERR_W = 8
);
    logic             Sample;
    logic             Complement;
    logic [3:0]       Ring_Q;
    logic [3:0]       John_Q;
    logic [1:0]       RingState;
    logic [2:0]       JohnState;
    logic             RingIllegal;
    logic             JohnIllegal;
    logic             RingSeqErr;
    logic             JohnSeqErr;
    logic             RingLock;
    logic             JohnLock;
    logic [ERR_W-1:0] ErrCount;

    modport master (
        output Sample, Complement, Ring_Q, John_Q,
        input  RingState, JohnState,
        input  RingIllegal, JohnIllegal,
        input  RingSeqErr, JohnSeqErr,
        input  RingLock, JohnLock, ErrCount
    );

    modport slave (
        input  Sample, Complement, Ring_Q, John_Q,
        output RingState, JohnState,
        output RingIllegal, JohnIllegal,
        output RingSeqErr, JohnSeqErr,
        output RingLock, JohnLock, ErrCount
    );
endinterface

// File: rtl/counter_pattern_decoder.sv
// Ring/Johnson pattern checker: decode, sequence tracking,
// per-channel lock and a saturating error total.
module counter_pattern_decoder #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input logic CLK,
    input logic Reset,
    counter_pattern_decoder_if.slave bus
);
    typedef enum logic {ACQ, TRACK} ch_t;

    localparam logic [3:0] LC = 4'(LOCK_COUNT);

    ch_t        r_st;
    ch_t        j_st;
    logic [3:0] r_run;
    logic [3:0] j_run;

    logic [3:0] rp;
    logic [3:0] jp;
    logic       r_ok;
    logic       j_ok;
    logic [1:0] r_code;
    logic [2:0] j_code;
    logic       r_adv;
    logic       j_adv;
    logic       r_rep;
    logic       j_rep;
    logic       r_err;
    logic       j_err;
    logic [1:0] err_inc;
    logic [ERR_W:0] err_sum;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        rp = bus.Complement ? ~bus.Ring_Q : bus.Ring_Q;
        jp = bus.Complement ? ~bus.John_Q : bus.John_Q;
        r_ok = 1'b1;
        r_code = 2'd0;
        case (rp)
            4'b0001: r_code = 2'd0;
            4'b0010: r_code = 2'd1;
            4'b0100: r_code = 2'd2;
            4'b1000: r_code = 2'd3;
            default: r_ok = 1'b0;
        endcase
        j_ok = 1'b1;
        j_code = 3'd0;
        case (jp)
            4'b0000: j_code = 3'd0;
            4'b0001: j_code = 3'd1;
            4'b0011: j_code = 3'd2;
            4'b0111: j_code = 3'd3;
            4'b1111: j_code = 3'd4;
            4'b1110: j_code = 3'd5;
            4'b1100: j_code = 3'd6;
            4'b1000: j_code = 3'd7;
            default: j_ok = 1'b0;
        endcase
    end

    // Modular state widths make 3->0 and 7->0 natural advances.
    always_comb begin
        r_adv = r_ok && r_st == TRACK
             && r_code == bus.RingState + 2'd1;
        j_adv = j_ok && j_st == TRACK
             && j_code == bus.JohnState + 3'd1;
        r_rep = r_ok && r_st == TRACK
             && r_code == bus.RingState;
        j_rep = j_ok && j_st == TRACK
             && j_code == bus.JohnState;
        r_err = !r_ok || (r_st == TRACK && !r_adv && !r_rep);
        j_err = !j_ok || (j_st == TRACK && !j_adv && !j_rep);
        err_inc = bus.Sample
                ? ({1'b0, r_err} + {1'b0, j_err}) : 2'd0;
        err_sum = {1'b0, bus.ErrCount} + (ERR_W+1)'(err_inc);
        err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_st            <= ACQ;
            j_st            <= ACQ;
            r_run           <= '0;
            j_run           <= '0;
            bus.RingState   <= '0;
            bus.JohnState   <= '0;
            bus.RingIllegal <= 1'b0;
            bus.JohnIllegal <= 1'b0;
            bus.RingSeqErr  <= 1'b0;
            bus.JohnSeqErr  <= 1'b0;
            bus.RingLock    <= 1'b0;
            bus.JohnLock    <= 1'b0;
            bus.ErrCount    <= '0;
        end else begin
            bus.RingIllegal <= 1'b0;
            bus.JohnIllegal <= 1'b0;
            bus.RingSeqErr  <= 1'b0;
            bus.JohnSeqErr  <= 1'b0;
            if (bus.Sample) begin
                bus.ErrCount <= err_next;
                case (r_st)
                    ACQ: begin
                        if (r_ok) begin
                            bus.RingState <= r_code;
                            r_run         <= '0;
                            r_st          <= TRACK;
                        end else begin
                            bus.RingIllegal <= 1'b1;
                        end
                    end
                    default: begin
                        if (!r_ok) begin
                            bus.RingIllegal <= 1'b1;
                            bus.RingLock    <= 1'b0;
                            r_run           <= '0;
                            r_st            <= ACQ;
                        end else if (r_adv) begin
                            bus.RingState <= r_code;
                            if (r_run != LC)
                                r_run <= r_run + 4'd1;
                            if (r_run >= LC - 4'd1)
                                bus.RingLock <= 1'b1;
                        end else if (!r_rep) begin
                            bus.RingSeqErr <= 1'b1;
                            bus.RingState  <= r_code;
                            bus.RingLock   <= 1'b0;
                            r_run          <= '0;
                        end
                    end
                endcase
                case (j_st)
                    ACQ: begin
                        if (j_ok) begin
                            bus.JohnState <= j_code;
                            j_run         <= '0;
                            j_st          <= TRACK;
                        end else begin
                            bus.JohnIllegal <= 1'b1;
                        end
                    end
                    default: begin
                        if (!j_ok) begin
                            bus.JohnIllegal <= 1'b1;
                            bus.JohnLock    <= 1'b0;
                            j_run           <= '0;
                            j_st            <= ACQ;
                        end else if (j_adv) begin
                            bus.JohnState <= j_code;
                            if (j_run != LC)
                                j_run <= j_run + 4'd1;
                            if (j_run >= LC - 4'd1)
                                bus.JohnLock <= 1'b1;
                        end else if (!j_rep) begin
                            bus.JohnSeqErr <= 1'b1;
                            bus.JohnState  <= j_code;
                            bus.JohnLock   <= 1'b0;
                            j_run          <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_counter_pattern_decoder.sv
// Directed bench for counter_pattern_decoder, including a
// narrow-counter instance to exercise ErrCount saturation.
module tb_counter_pattern_decoder;
    logic CLK;
    logic Reset;
    int   checks;
    int   errors;

    counter_pattern_decoder_if #(.ERR_W(8)) a ();
    counter_pattern_decoder_if #(.ERR_W(2)) b ();

    counter_pattern_decoder #(.LOCK_COUNT(4), .ERR_W(8)) dut (
        .CLK(CLK), .Reset(Reset), .bus(a.slave)
    );
    counter_pattern_decoder #(.LOCK_COUNT(4), .ERR_W(2)) dut2 (
        .CLK(CLK), .Reset(Reset), .bus(b.slave)
    );

    assign b.Sample     = a.Sample;
    assign b.Complement = a.Complement;
    assign b.Ring_Q     = a.Ring_Q;
    assign b.John_Q     = a.John_Q;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic samp(input logic [3:0] r,
                        input logic [3:0] j,
                        input logic c);
        a.Ring_Q = r;
        a.John_Q = j;
        a.Complement = c;
        a.Sample = 1'b1;
        @(posedge CLK);
        #1;
        a.Sample = 1'b0;
    endtask

    task automatic idle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rs"}, 32'(a.RingState), 0);
        chk({tag, "_js"}, 32'(a.JohnState), 0);
        chk({tag, "_pulses"},
            {28'd0, a.RingIllegal, a.JohnIllegal,
             a.RingSeqErr, a.JohnSeqErr}, 0);
        chk({tag, "_locks"}, {30'd0, a.RingLock, a.JohnLock}, 0);
        chk({tag, "_err"}, 32'(a.ErrCount), 0);
        chk({tag, "_err2"}, 32'(b.ErrCount), 0);
    endtask

    initial begin
        logic [3:0] rv [5];
        logic [3:0] jv [5];
        checks = 0;
        errors = 0;
        Reset = 1'b1;
        a.Sample = 1'b0;
        a.Complement = 1'b0;
        a.Ring_Q = '0;
        a.John_Q = '0;
        idle();
        idle();
        chk_zero("reset");
        Reset = 1'b0;

        rv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        jv = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            samp(rv[i], jv[i], 1'b0);
            chk("t1_rs", 32'(a.RingState), 32'(i % 4));
            chk("t1_js", 32'(a.JohnState), 32'(i));
            chk("t1_rlock", 32'(a.RingLock), (i == 4) ? 1 : 0);
            chk("t1_jlock", 32'(a.JohnLock), (i == 4) ? 1 : 0);
        end
        chk("t1_err", 32'(a.ErrCount), 0);
        samp(4'b0001, 4'b1111, 1'b0);
        chk("rep_rs", 32'(a.RingState), 0);
        chk("rep_js", 32'(a.JohnState), 4);
        chk("rep_locks", {30'd0, a.RingLock, a.JohnLock}, 3);
        chk("rep_seq", {30'd0, a.RingSeqErr, a.JohnSeqErr}, 0);
        chk("rep_err", 32'(a.ErrCount), 0);

        do_reset();
        samp(4'b1110, 4'b1111, 1'b1);
        chk("t2_rs0", 32'(a.RingState), 0);
        chk("t2_js0", 32'(a.JohnState), 0);
        samp(4'b1101, 4'b1110, 1'b1);
        chk("t2_rs1", 32'(a.RingState), 1);
        chk("t2_js1", 32'(a.JohnState), 1);
        chk("t2_err", 32'(a.ErrCount), 0);

        do_reset();
        rv = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        jv = '{4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
        for (int i = 0; i < 5; i++) samp(rv[i], jv[i], 1'b0);
        chk("t3_pre_js", 32'(a.JohnState), 3);
        chk("t3_pre_lock", {30'd0, a.RingLock, a.JohnLock}, 3);
        chk("t3_pre_err", 32'(a.ErrCount), 0);
        samp(4'b1000, 4'b0110, 1'b0);
        chk("t3_jill", 32'(a.JohnIllegal), 1);
        chk("t3_jlock", 32'(a.JohnLock), 0);
        chk("t3_js", 32'(a.JohnState), 3);
        chk("t3_rlock", 32'(a.RingLock), 1);
        chk("t3_err", 32'(a.ErrCount), 1);
        chk("t3_err2", 32'(b.ErrCount), 1);
        idle();
        chk("t3_idle_jill", 32'(a.JohnIllegal), 0);
        samp(4'b1000, 4'b0001, 1'b0);
        chk("t3_acq_seq", 32'(a.JohnSeqErr), 0);
        chk("t3_acq_js", 32'(a.JohnState), 1);
        chk("t3_acq_err", 32'(a.ErrCount), 1);

        samp(4'b0001, 4'b0011, 1'b0);
        samp(4'b0010, 4'b0111, 1'b0);
        chk("t4_pre_rs", 32'(a.RingState), 1);
        samp(4'b1000, 4'b1111, 1'b0);
        chk("t4_rseq", 32'(a.RingSeqErr), 1);
        chk("t4_rs", 32'(a.RingState), 3);
        chk("t4_rlock", 32'(a.RingLock), 0);
        chk("t4_jseq", 32'(a.JohnSeqErr), 0);
        chk("t4_err", 32'(a.ErrCount), 2);
        samp(4'b0001, 4'b1110, 1'b0);
        chk("t4_adv_rseq", 32'(a.RingSeqErr), 0);
        chk("t4_adv_rs", 32'(a.RingState), 0);
        chk("t4_adv_js", 32'(a.JohnState), 5);
        chk("t4_adv_err", 32'(a.ErrCount), 2);

        samp(4'b0011, 4'b0101, 1'b0);
        chk("t5_ill", {30'd0, a.RingIllegal, a.JohnIllegal}, 3);
        chk("t5_err", 32'(a.ErrCount), 4);
        chk("t5_err2", 32'(b.ErrCount), 3);
        samp(4'b0000, 4'b1010, 1'b0);
        chk("t5_err_more", 32'(a.ErrCount), 6);
        chk("t5_sat", 32'(b.ErrCount), 3);

        Reset = 1'b1;
        samp(4'b0010, 4'b0001, 1'b0);
        Reset = 1'b0;
        chk_zero("rst_samp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
